ram_access_ctrl: RTL and testbench

//  Bus-master controller that drives the combinational RAM block's address/datain/read/write

---
 rtl/ram_access_ctrl_if.sv | 33 +++
 rtl/ram_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake and RAM pin bundle for ram_access_ctrl.
// slave = the controller; master = the CPU side that also models the RAM pins.
interface ram_access_ctrl_if #(
  parameter int adlines   = 8,
  parameter int datalines = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [adlines-1:0]   req_addr;
  logic [datalines-1:0] req_wdata;
  logic                 rsp_valid;
  logic [datalines-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 busy;
  logic [adlines-1:0]   ram_address;
  logic [datalines-1:0] ram_datain;
  logic                 ram_read;
  logic                 ram_write;
  logic [datalines-1:0] ram_dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ram_dataout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           ram_address, ram_datain, ram_read, ram_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ram_dataout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           ram_address, ram_datain, ram_read, ram_write
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// RAM bus master: sequences SETUP/ACCESS/DONE strobes for CPU load/store requests,
// with one pending slot so back-to-back requests run without an IDLE bubble.
module ram_access_ctrl #(
  parameter int adlines     = 8,
  parameter int datalines   = 16,
  parameter int ramsize     = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  ram_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_write_q, op_write_d;
  logic                 op_err_q, op_err_d;
  logic [adlines-1:0]   op_addr_q, op_addr_d;
  logic [datalines-1:0] op_wdata_q, op_wdata_d;
  logic                 pend_full_q, pend_full_d;
  logic                 pend_write_q, pend_write_d;
  logic [adlines-1:0]   pend_addr_q, pend_addr_d;
  logic [datalines-1:0] pend_wdata_q, pend_wdata_d;
  logic [datalines-1:0] rdata_q, rdata_d;
  logic                 accept;
  logic                 strobe_en;

  function automatic logic out_of_range(input logic [adlines-1:0] a);
    return 32'(a) >= 32'(ramsize);
  endfunction

  assign accept = bus.req_valid & ~pend_full_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_write_d   = op_write_q;
    op_err_d     = op_err_q;
    op_addr_d    = op_addr_q;
    op_wdata_d   = op_wdata_q;
    pend_full_d  = pend_full_q;
    pend_write_d = pend_write_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    rdata_d      = rdata_q;

    // Requests arriving mid-operation park in the pending slot.
    if (accept && (state_q == SETUP || state_q == ACCESS)) begin
      pend_full_d  = 1'b1;
      pend_write_d = bus.req_write;
      pend_addr_d  = bus.req_addr;
      pend_wdata_d = bus.req_write ? bus.req_wdata : '0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_write_d = bus.req_write;
          op_addr_d  = bus.req_addr;
          op_wdata_d = bus.req_write ? bus.req_wdata : '0;
          op_err_d   = out_of_range(bus.req_addr);
          state_d    = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          rdata_d = (!op_write_q && !op_err_q) ? bus.ram_dataout : '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // A request accepted during DONE (slot empty) starts directly, keeping order.
        if (pend_full_q) begin
          op_write_d  = pend_write_q;
          op_addr_d   = pend_addr_q;
          op_wdata_d  = pend_wdata_q;
          op_err_d    = out_of_range(pend_addr_q);
          pend_full_d = 1'b0;
          state_d     = SETUP;
        end else if (accept) begin
          op_write_d = bus.req_write;
          op_addr_d  = bus.req_addr;
          op_wdata_d = bus.req_write ? bus.req_wdata : '0;
          op_err_d   = out_of_range(bus.req_addr);
          state_d    = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_write_q   <= 1'b0;
      op_err_q     <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      pend_full_q  <= 1'b0;
      pend_write_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_write_q   <= op_write_d;
      op_err_q     <= op_err_d;
      op_addr_q    <= op_addr_d;
      op_wdata_q   <= op_wdata_d;
      pend_full_q  <= pend_full_d;
      pend_write_q <= pend_write_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them immediately.
  assign strobe_en       = (state_q == ACCESS) & ~op_err_q;
  assign bus.ram_read    = strobe_en & ~op_write_q;
  assign bus.ram_write   = strobe_en & op_write_q;
  assign bus.ram_address = op_addr_q;
  assign bus.ram_datain  = op_wdata_q;
  assign bus.req_ready   = ~pend_full_q;
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.rsp_rdata   = (state_q == DONE) ? rdata_q : '0;
  assign bus.rsp_err     = (state_q == DONE) & op_err_q;
  assign bus.busy        = (state_q != IDLE) | pend_full_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: one instance with no wait states, one with two,
// each backed by a behavioural RAM that writes on the clock edge while ram_write is high.
module tb_ram_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mon_err = 0;

  ram_access_ctrl_if #(.adlines(AW), .datalines(DW)) b0 ();
  ram_access_ctrl_if #(.adlines(AW), .datalines(DW)) b2 ();

  ram_access_ctrl #(.adlines(AW), .datalines(DW), .ramsize(256), .WAIT_CYCLES(0))
    d0 (.clk(clk), .reset(reset), .bus(b0));
  ram_access_ctrl #(.adlines(AW), .datalines(DW), .ramsize(256), .WAIT_CYCLES(2))
    d2 (.clk(clk), .reset(reset), .bus(b2));

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem2 [256];

  always @(posedge clk) begin
    if (b0.ram_write) mem0[b0.ram_address[7:0]] <= b0.ram_datain;
    if (b2.ram_write) mem2[b2.ram_address[7:0]] <= b2.ram_datain;
  end
  assign b0.ram_dataout = mem0[b0.ram_address[7:0]];
  assign b2.ram_dataout = mem2[b2.ram_address[7:0]];

  // Continuous bus-protocol watch on both instances.
  logic [AW-1:0] pa0 = '0, pa2 = '0;
  logic          ps0 = 1'b0, ps2 = 1'b0;
  always @(negedge clk) begin
    assert (!(b0.ram_read && b0.ram_write)) else begin
      mon_err++; $error("FAIL strobe_excl0 observed rd=%b wr=%b expected not both", b0.ram_read, b0.ram_write);
    end
    assert (!(b2.ram_read && b2.ram_write)) else begin
      mon_err++; $error("FAIL strobe_excl2 observed rd=%b wr=%b expected not both", b2.ram_read, b2.ram_write);
    end
    assert (!((b0.ram_read || b0.ram_write) && b0.ram_address[8])) else begin
      mon_err++; $error("FAIL oor_strobe0 observed addr=%0h with strobe expected no strobe", b0.ram_address);
    end
    assert (!(ps0 && (b0.ram_read || b0.ram_write) && b0.ram_address !== pa0)) else begin
      mon_err++; $error("FAIL addr_stable0 observed %0h expected %0h", b0.ram_address, pa0);
    end
    assert (!(ps2 && (b2.ram_read || b2.ram_write) && b2.ram_address !== pa2)) else begin
      mon_err++; $error("FAIL addr_stable2 observed %0h expected %0h", b2.ram_address, pa2);
    end
    ps0 <= b0.ram_read | b0.ram_write;
    pa0 <= b0.ram_address;
    ps2 <= b2.ram_read | b2.ram_write;
    pa2 <= b2.ram_address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input int w);  return (w == 2) ? b2.req_ready : b0.req_ready;  endfunction
  function automatic logic f_rsp(input int w);    return (w == 2) ? b2.rsp_valid : b0.rsp_valid;  endfunction
  function automatic logic f_err(input int w);    return (w == 2) ? b2.rsp_err   : b0.rsp_err;    endfunction
  function automatic logic f_busy(input int w);   return (w == 2) ? b2.busy      : b0.busy;       endfunction
  function automatic logic [DW-1:0] f_rdata(input int w); return (w == 2) ? b2.rsp_rdata : b0.rsp_rdata; endfunction
  function automatic logic [AW-1:0] f_addr(input int w);  return (w == 2) ? b2.ram_address : b0.ram_address; endfunction
  function automatic logic f_strobe(input int w);
    return (w == 2) ? (b2.ram_read | b2.ram_write) : (b0.ram_read | b0.ram_write);
  endfunction

  task automatic drive(input int w, input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w == 2) begin
      b2.req_valid = v; b2.req_write = wr; b2.req_addr = a; b2.req_wdata = d;
    end else begin
      b0.req_valid = v; b0.req_write = wr; b0.req_addr = a; b0.req_wdata = d;
    end
  endtask

  // Present a request and return #1 after the edge that accepts it.
  task automatic issue(input int w, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    drive(w, 1'b1, wr, a, d);
    forever begin
      @(negedge clk);
      if (f_ready(w)) break;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'(f_ready(w)), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, '0, '0);
  endtask

  // rsp_valid must stay low for lat-1 cycles after acceptance and be high in the lat-th.
  task automatic wait_rsp(input int w, input int lat, output logic [DW-1:0] rd, output logic er, output int st);
    st = 0; rd = '0; er = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (f_strobe(w)) st++;
      if (k < lat) chk("rsp_early", 32'(f_rsp(w)), 32'd0);
      else begin
        chk("rsp_valid", 32'(f_rsp(w)), 32'd1);
        rd = f_rdata(w);
        er = f_err(w);
      end
    end
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            st;
  logic [DW-1:0] sb [16];
  logic          rwr, roor;
  logic [3:0]    ridx;
  logic [DW-1:0] rdat;
  logic [AW-1:0] raddr;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #12;
    for (int w = 0; w <= 2; w += 2) begin
      chk("rst_ready", 32'(f_ready(w)), 32'd1);
      chk("rst_rsp", 32'(f_rsp(w)), 32'd0);
      chk("rst_busy", 32'(f_busy(w)), 32'd0);
      chk("rst_strobe", 32'(f_strobe(w)), 32'd0);
      chk("rst_addr", 32'(f_addr(w)), 32'd0);
      chk("rst_rdata", 32'(f_rdata(w)), 32'd0);
      chk("rst_err", 32'(f_err(w)), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // No wait states: store then load back, 3-cycle latency, one strobe cycle each.
    issue(0, 1'b1, 9'h010, 16'h000F);
    wait_rsp(0, 3, rd, er, st);
    chk("w0_st_strobe", 32'(st), 32'd1);
    chk("w0_st_err", 32'(er), 32'd0);
    chk("w0_st_rdata", 32'(rd), 32'd0);
    issue(0, 1'b0, 9'h010, 16'h0000);
    wait_rsp(0, 3, rd, er, st);
    chk("w0_ld_strobe", 32'(st), 32'd1);
    chk("w0_ld_err", 32'(er), 32'd0);
    chk("w0_ld_rdata", 32'(rd), 32'h000F);

    // Two wait states: strobe held 3 cycles, response 5 cycles after acceptance.
    issue(2, 1'b1, 9'h011, 16'h0004);
    wait_rsp(2, 5, rd, er, st);
    chk("w2_st_strobe", 32'(st), 32'd3);
    issue(2, 1'b0, 9'h011, 16'h0000);
    wait_rsp(2, 5, rd, er, st);
    chk("w2_ld_strobe", 32'(st), 32'd3);
    chk("w2_ld_err", 32'(er), 32'd0);
    chk("w2_ld_rdata", 32'(rd), 32'h0004);

    // Reset in the middle of a store's ACCESS cycle.
    issue(0, 1'b1, 9'h030, 16'h1234);
    wait_rsp(0, 3, rd, er, st);
    issue(0, 1'b1, 9'h030, 16'h5555);
    @(posedge clk); #2;
    chk("rst_mid_wr_before", 32'(b0.ram_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_wr_drop", 32'(b0.ram_write), 32'd0);
    chk("rst_mid_rsp", 32'(b0.rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(b0.rsp_valid), 32'd0);
      chk("rst_mid_busy", 32'(b0.busy), 32'd0);
      chk("rst_mid_ready", 32'(b0.req_ready), 32'd1);
    end
    @(posedge clk); #1;
    issue(0, 1'b0, 9'h030, 16'h0000);
    wait_rsp(0, 3, rd, er, st);
    chk("rst_mid_word_kept", 32'(rd), 32'h1234);

    // Three requests with req_valid held high.
    drive(0, 1'b1, 1'b1, 9'h040, 16'hAAAA);
    @(negedge clk); chk("b2b_ready_c0", 32'(b0.req_ready), 32'd1);
    @(posedge clk); #1; drive(0, 1'b1, 1'b0, 9'h040, 16'h0000);
    @(negedge clk); chk("b2b_ready_c1", 32'(b0.req_ready), 32'd1);
    chk("b2b_setup_strobe", 32'(f_strobe(0)), 32'd0);
    @(posedge clk); #1; drive(0, 1'b1, 1'b0, 9'h010, 16'h0000);
    @(negedge clk); chk("b2b_ready_c2", 32'(b0.req_ready), 32'd0);
    chk("b2b_wr_c2", 32'(b0.ram_write), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_ready_c3", 32'(b0.req_ready), 32'd0);
    chk("b2b_rsp1", 32'(b0.rsp_valid), 32'd1);
    chk("b2b_rdata1", 32'(b0.rsp_rdata), 32'h0000);
    chk("b2b_strobe_done", 32'(f_strobe(0)), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_ready_c4", 32'(b0.req_ready), 32'd1);
    chk("b2b_busy_c4", 32'(b0.busy), 32'd1);
    chk("b2b_addr_op2", 32'(b0.ram_address), 32'h040);
    chk("b2b_rsp_c4", 32'(b0.rsp_valid), 32'd0);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); chk("b2b_rd_c5", 32'(b0.ram_read), 32'd1);
    chk("b2b_ready_c5", 32'(b0.req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_rsp2", 32'(b0.rsp_valid), 32'd1);
    chk("b2b_rdata2", 32'(b0.rsp_rdata), 32'hAAAA);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_addr_op3", 32'(b0.ram_address), 32'h010);
    chk("b2b_rsp_c7", 32'(b0.rsp_valid), 32'd0);
    chk("b2b_ready_c7", 32'(b0.req_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_rd_c8", 32'(b0.ram_read), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_rsp3", 32'(b0.rsp_valid), 32'd1);
    chk("b2b_rdata3", 32'(b0.rsp_rdata), 32'h000F);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_idle_busy", 32'(b0.busy), 32'd0);
    chk("b2b_idle_rsp", 32'(b0.rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Out-of-range addresses: timing unchanged, no strobes, error flagged.
    issue(0, 1'b0, 9'h100, 16'h0000);
    wait_rsp(0, 3, rd, er, st);
    chk("oor_ld_strobe", 32'(st), 32'd0);
    chk("oor_ld_err", 32'(er), 32'd1);
    chk("oor_ld_rdata", 32'(rd), 32'd0);
    issue(0, 1'b1, 9'h1FF, 16'hDEAD);
    wait_rsp(0, 3, rd, er, st);
    chk("oor_st_strobe", 32'(st), 32'd0);
    chk("oor_st_err", 32'(er), 32'd1);

    // Random traffic against a scoreboard over 16 words at 0x20..0x2F.
    for (int i = 0; i < 16; i++) begin
      sb[i] = 16'($urandom);
      issue(0, 1'b1, 9'h020 + 9'(i), sb[i]);
      wait_rsp(0, 3, rd, er, st);
    end
    for (int n = 0; n < 1000; n++) begin
      rwr  = 1'($urandom_range(0, 1));
      roor = ($urandom_range(0, 9) == 0);
      ridx = 4'($urandom_range(0, 15));
      rdat = 16'($urandom);
      raddr = roor ? (9'h100 | 9'($urandom_range(0, 255))) : (9'h020 + 9'(ridx));
      issue(0, rwr, raddr, rdat);
      wait_rsp(0, 3, rd, er, st);
      if (roor) begin
        chk("rnd_oor_err", 32'(er), 32'd1);
        chk("rnd_oor_strobe", 32'(st), 32'd0);
        chk("rnd_oor_rdata", 32'(rd), 32'd0);
      end else begin
        chk("rnd_err", 32'(er), 32'd0);
        chk("rnd_strobe", 32'(st), 32'd1);
        chk("rnd_rdata", 32'(rd), rwr ? 32'd0 : 32'(sb[ridx]));
        if (rwr) sb[ridx] = rdat;
      end
    end

    chk("protocol_monitor", 32'(mon_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
